// File: rtl/vec_pkg.sv
// Shared definitions for the vector load/store sequencer.
package vec_pkg;

  localparam int ELEM_W   = 16;
  localparam int NUM_ELEM = 16;
  localparam int ADDR_W   = 16;
  localparam int VEC_W    = ELEM_W * NUM_ELEM;

  localparam logic [3:0] VLD = 4'b0100;
  localparam logic [3:0] VST = 4'b0101;

  typedef enum logic [1:0] {IDLE, LOAD, STORE, DONE} state_e;

endpackage

// File: rtl/vec_shadow_buf.sv
// Capture buffer for returning load elements: indexed write, full-width parallel read.
module vec_shadow_buf #(
  parameter int ELEM_W   = 16,
  parameter int NUM_ELEM = 16,
  localparam int IDX_W   = $clog2(NUM_ELEM)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [IDX_W-1:0]             wr_idx,
  input  logic [ELEM_W-1:0]            wr_data,
  output logic [ELEM_W*NUM_ELEM-1:0]   rd_all
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ELEM; gi++) begin : g_elem
      logic [ELEM_W-1:0] elem_q;
      logic [ELEM_W-1:0] elem_d;

      always_comb begin
        elem_d = elem_q;
        if (wr_en && (wr_idx == IDX_W'(gi))) begin
          elem_d = wr_data;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          elem_q <= '0;
        end else begin
          elem_q <= elem_d;
        end
      end

      assign rd_all[gi*ELEM_W +: ELEM_W] = elem_q;
    end
  endgenerate

endmodule

// File: rtl/vec_mem_seq.sv
// Vector load/store sequencer: moves a NUM_ELEM-element vector over a one-element
// memory port, with independent issue and return sides for loads.
module vec_mem_seq #(
  parameter int ELEM_W   = 16,
  parameter int NUM_ELEM = 16,
  parameter int ADDR_W   = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        is_store,
  input  logic [ADDR_W-1:0]           base_addr,
  input  logic [ELEM_W*NUM_ELEM-1:0]  st_data,
  output logic                        busy,
  output logic                        done,
  output logic [ELEM_W*NUM_ELEM-1:0]  ld_data,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic                        mem_re,
  output logic                        mem_we,
  output logic [ELEM_W-1:0]           mem_wdata,
  input  logic                        mem_rdy,
  input  logic                        mem_rvalid,
  input  logic [ELEM_W-1:0]           mem_rdata
);

  import vec_pkg::*;

  localparam int VEC_BITS = ELEM_W * NUM_ELEM;
  localparam int IDX_W    = $clog2(NUM_ELEM);
  localparam int CNT_W    = $clog2(NUM_ELEM) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_ELEM - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_ELEM);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      issue_q, issue_d;
  logic [CNT_W-1:0]      ret_q, ret_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic [VEC_BITS-1:0]   st_q, st_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [VEC_BITS-1:0]   ld_q, ld_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  re_q, re_d;
  logic                  we_q, we_d;
  logic [ELEM_W-1:0]     wdata_q, wdata_d;

  logic [CNT_W-1:0]      issue_nxt;
  logic                  issue_last;
  logic                  ret_fire;
  logic [VEC_BITS-1:0]   shadow_all;
  logic [VEC_BITS-1:0]   commit_vec;
  logic [ELEM_W-1:0]     st_elem [NUM_ELEM];

  assign issue_nxt  = issue_q + CNT_W'(1);
  assign issue_last = (issue_q == CNT_LAST);
  assign ret_fire   = (state_q == LOAD) && mem_rvalid && (ret_q < CNT_FULL);

  vec_shadow_buf #(
    .ELEM_W   (ELEM_W),
    .NUM_ELEM (NUM_ELEM)
  ) u_shadow (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (ret_fire),
    .wr_idx  (ret_q[IDX_W-1:0]),
    .wr_data (mem_rdata),
    .rd_all  (shadow_all)
  );

  // The final element lands in the buffer on the same edge as the commit,
  // so the commit vector folds the in-flight return over the stored copy.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_ELEM; gi++) begin : g_lane
      assign st_elem[gi] = st_q[gi*ELEM_W +: ELEM_W];
      assign commit_vec[gi*ELEM_W +: ELEM_W] =
        (ret_fire && (ret_q[IDX_W-1:0] == IDX_W'(gi))) ? mem_rdata
                                                        : shadow_all[gi*ELEM_W +: ELEM_W];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    issue_d = issue_q;
    ret_d   = ret_q;
    base_d  = base_q;
    st_d    = st_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ld_d    = ld_q;
    addr_d  = addr_q;
    re_d    = re_q;
    we_d    = we_q;
    wdata_d = wdata_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = base_addr;
          issue_d = '0;
          ret_d   = '0;
          busy_d  = 1'b1;
          addr_d  = base_addr;
          if (is_store) begin
            st_d    = st_data;
            we_d    = 1'b1;
            wdata_d = st_data[ELEM_W-1:0];
            state_d = STORE;
          end else begin
            re_d    = 1'b1;
            state_d = LOAD;
          end
        end
      end

      STORE: begin
        if (mem_rdy) begin
          issue_d = issue_nxt;
          if (issue_last) begin
            we_d    = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            addr_d  = base_q + ADDR_W'(issue_nxt);
            wdata_d = st_elem[issue_nxt[IDX_W-1:0]];
          end
        end
      end

      LOAD: begin
        if ((issue_q < CNT_FULL) && mem_rdy) begin
          issue_d = issue_nxt;
          if (issue_last) begin
            re_d = 1'b0;
          end else begin
            addr_d = base_q + ADDR_W'(issue_nxt);
          end
        end
        if (ret_fire) begin
          ret_d = ret_q + CNT_W'(1);
          if (ret_q == CNT_LAST) begin
            ld_d    = commit_vec;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      issue_q <= '0;
      ret_q   <= '0;
      base_q  <= '0;
      st_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ld_q    <= '0;
      addr_q  <= '0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      issue_q <= issue_d;
      ret_q   <= ret_d;
      base_q  <= base_d;
      st_q    <= st_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ld_q    <= ld_d;
      addr_q  <= addr_d;
      re_q    <= re_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign ld_data   = ld_q;
  assign mem_addr  = addr_q;
  assign mem_re    = re_q;
  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;

endmodule
